// File: rtl/zbt_point_pattern_writer_pkg.sv
// Shared definitions for the ZBT point-pattern writer.
// Contents: FSM state type, marker count, the marker sign table and a small index-width helper.
package zbt_point_pattern_writer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrid,
    StMark,
    StFin
  } state_e;

  localparam int unsigned NumMarkers = 4;

  // Marker k uses a negative y when MarkYNeg[k] is set and a negative z when MarkZNeg[k] is set.
  // This gives the order (+,+), (-,+), (+,-), (-,-).
  localparam logic [3:0] MarkYNeg = 4'b1010;
  localparam logic [3:0] MarkZNeg = 4'b1100;

  // Width of an index counting 0..n-1. It is never zero, so a 1-point grid still elaborates.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zbt_point_pattern_writer_axis_index_counter.sv
// Three-axis nested lattice index counter.
// z counts innermost, then y, then x. Each axis runs 0..GRID_N-1.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset; clears all indices
//   clear         synchronous clear back to index (0,0,0)
//   advance       step to the next lattice point
//   x_nxt/y_nxt/z_nxt  indices the counter moves to on advance (combinational)
//   last          current point is the final one (all indices at GRID_N-1)
module zbt_point_pattern_writer_axis_index_counter
  import zbt_point_pattern_writer_pkg::*;
#(
  parameter int unsigned GRID_N = 3,
  parameter int unsigned IDX_W  = idx_width(GRID_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] x_nxt,
  output logic [IDX_W-1:0] y_nxt,
  output logic [IDX_W-1:0] z_nxt,
  output logic             last
);

  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(GRID_N - 1);

  logic [IDX_W-1:0] x_q, y_q, z_q;

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    z_nxt = z_q;
    if (z_q != IdxMax) begin
      z_nxt = z_q + IDX_W'(1);
    end else begin
      z_nxt = '0;
      if (y_q != IdxMax) begin
        y_nxt = y_q + IDX_W'(1);
      end else begin
        y_nxt = '0;
        x_nxt = (x_q != IdxMax) ? x_q + IDX_W'(1) : '0;
      end
    end
  end

  assign last = (x_q == IdxMax) && (y_q == IdxMax) && (z_q == IdxMax);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (advance) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
      z_q <= z_nxt;
    end
  end

endmodule

// File: rtl/zbt_point_pattern_writer.sv
// Synthetic point-cloud writer for ZBT SRAM bring-up.
// Writes a centred GRID_N^3 lattice. With mode=1 it then writes 4 orientation markers.
// Each point is one word {pad, x, y, z}, written through a wr_en/wr_ready handshake.
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   start        begin a run (sampled only while idle)
//   mode         0 = lattice only, 1 = lattice + 4 markers
//   base_addr    address of the first word
//   max_count    cap on words written in a run (0 = write nothing)
//   wr_ready     write port accepts the presented word this cycle
//   wr_en        word valid on wr_addr/wr_data; held stable until accepted
//   wr_addr      ZBT word address; wraps modulo 2^ADDR_W
//   wr_data      packed point, x in the MSBs, zero-padded above
//   busy         run in progress
//   done         one-cycle pulse at the end of a run
//   count        words accepted in the current/last run
module zbt_point_pattern_writer
  import zbt_point_pattern_writer_pkg::*;
#(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned WORD_W  = 36,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned GRID_N  = 3,
  parameter int unsigned STEP    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] max_count,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);

  localparam int unsigned IDX_W = idx_width(GRID_N);
  localparam int unsigned CW2   = COORD_W + 2;
  localparam int          Half  = (int'(GRID_N) - 1) / 2;

  // Marker coordinates, formed at CW2 bits and then truncated like the lattice coordinates.
  localparam logic signed [CW2-1:0] MarkXW   = CW2'((int'(GRID_N) - 1 - Half + 2) * int'(STEP));
  localparam logic signed [CW2-1:0] MarkPosW = CW2'(Half * int'(STEP));
  localparam logic signed [CW2-1:0] MarkNegW = -MarkPosW;
  localparam logic [COORD_W-1:0]    MarkX    = MarkXW[COORD_W-1:0];
  localparam logic [COORD_W-1:0]    MarkPos  = MarkPosW[COORD_W-1:0];
  localparam logic [COORD_W-1:0]    MarkNeg  = MarkNegW[COORD_W-1:0];

  function automatic logic [WORD_W-1:0] pack_point(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y,
                                                   logic [COORD_W-1:0] z);
    return WORD_W'({x, y, z});
  endfunction

  // Index i maps to (i - Half) * STEP. The product is computed at CW2 bits, then truncated.
  function automatic logic [COORD_W-1:0] idx_to_coord(logic [IDX_W-1:0] idx);
    logic signed [CW2-1:0] t;
    t = signed'(CW2'(idx)) - signed'(CW2'(Half));
    t = t * signed'(CW2'(STEP));
    return t[COORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] mark_word(logic [1:0] k);
    logic [COORD_W-1:0] y, z;
    y = MarkYNeg[k] ? MarkNeg : MarkPos;
    z = MarkZNeg[k] ? MarkNeg : MarkPos;
    return pack_point(MarkX, y, z);
  endfunction

  state_e            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] max_q;
  logic [1:0]        mark_q;

  logic              accept;
  logic [ADDR_W-1:0] count_inc;
  logic              cap_hit;
  logic              grid_clear;
  logic              grid_advance;
  logic              grid_last;
  logic [IDX_W-1:0]  x_nxt, y_nxt, z_nxt;

  assign accept       = wr_en && wr_ready;
  assign count_inc    = count + ADDR_W'(1);
  assign cap_hit      = (count_inc == max_q);
  assign grid_clear   = (state_q == StIdle) && start;
  assign grid_advance = (state_q == StGrid) && accept;

  zbt_point_pattern_writer_axis_index_counter #(
    .GRID_N(GRID_N),
    .IDX_W (IDX_W)
  ) u_axis_index_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (grid_clear),
    .advance(grid_advance),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .z_nxt  (z_nxt),
    .last   (grid_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      max_q   <= '0;
      mark_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            max_q   <= max_count;
            mark_q  <= '0;
            count   <= '0;
            wr_addr <= base_addr;
            if (max_count == '0) begin
              state_q <= StFin;
            end else begin
              state_q <= StGrid;
              wr_en   <= 1'b1;
              busy    <= 1'b1;
              wr_data <= pack_point(idx_to_coord('0), idx_to_coord('0), idx_to_coord('0));
            end
          end
        end
        StGrid: begin
          if (accept) begin
            count   <= count_inc;
            wr_addr <= wr_addr + ADDR_W'(1);
            if (cap_hit || (grid_last && !mode_q)) begin
              state_q <= StFin;
              wr_en   <= 1'b0;
              busy    <= 1'b0;
            end else if (grid_last) begin
              state_q <= StMark;
              mark_q  <= '0;
              wr_data <= mark_word(2'd0);
            end else begin
              wr_data <= pack_point(idx_to_coord(x_nxt), idx_to_coord(y_nxt), idx_to_coord(z_nxt));
            end
          end
        end
        StMark: begin
          if (accept) begin
            count   <= count_inc;
            wr_addr <= wr_addr + ADDR_W'(1);
            if (cap_hit || (mark_q == 2'(NumMarkers - 1))) begin
              state_q <= StFin;
              wr_en   <= 1'b0;
              busy    <= 1'b0;
            end else begin
              mark_q  <= mark_q + 2'd1;
              wr_data <= mark_word(mark_q + 2'd1);
            end
          end
        end
        StFin: begin
          // start is deliberately not looked at here.
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zbt_point_pattern_writer.sv
module tb_zbt_point_pattern_writer;

  localparam int N    = 3;
  localparam int STEP = 100;

  logic        clk = 1'b0;
  logic        reset, start, mode, wr_ready;
  logic [18:0] base_addr, max_count;
  logic        wr_en, busy, done;
  logic [18:0] wr_addr, count;
  logic [35:0] wr_data;

  always #5 clk = ~clk;

  zbt_point_pattern_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .base_addr(base_addr),
    .max_count(max_count),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  typedef struct {
    logic        m;
    logic [18:0] base;
    logic [18:0] max;
    logic        rnd;
    int          poke;
    int          exp_n;
    int          exp_done;  // -1: derive from the last accept cycle
  } vec_t;

  typedef struct {
    int          run;
    int          idx;
    logic [18:0] addr;
    logic [35:0] data;
  } spot_t;

  vec_t        vecs[10];
  spot_t       spots[11];
  logic [35:0] exp_q[$];
  logic [18:0] cap_a[64];
  logic [35:0] cap_d[64];
  int          cap_n;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [35:0] pk(input int x, input int y, input int z);
    logic [9:0] xs, ys, zs;
    xs = 10'(x);
    ys = 10'(y);
    zs = 10'(z);
    return {6'd0, xs, ys, zs};
  endfunction

  // Reference point list for a run, trimmed to the word cap.
  task automatic build_expected(input logic m, input logic [18:0] cap);
    int half, mx, mm;
    half = (N - 1) / 2;
    exp_q.delete();
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        for (int z = 0; z < N; z++)
          exp_q.push_back(pk((x - half) * STEP, (y - half) * STEP, (z - half) * STEP));
    if (m) begin
      mx = (N - 1 - half) * STEP + 2 * STEP;
      mm = half * STEP;
      exp_q.push_back(pk(mx, mm, mm));
      exp_q.push_back(pk(mx, -mm, mm));
      exp_q.push_back(pk(mx, mm, -mm));
      exp_q.push_back(pk(mx, -mm, -mm));
    end
    while (exp_q.size() > int'(cap)) void'(exp_q.pop_back());
  endtask

  function automatic logic pick(input logic rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int          k, done_at, last_acc, exp_done;
    bit          seen, prev_stall;
    logic [18:0] pa, ea;
    logic [35:0] pd;
    build_expected(v.m, v.max);
    k = 0; done_at = -1; last_acc = -1; seen = 0; prev_stall = 0; pa = '0; pd = '0;
    @(negedge clk);
    start = 1'b1; mode = v.m; base_addr = v.base; max_count = v.max; wr_ready = pick(v.rnd);
    @(negedge clk);
    // Outputs here reflect the edge es cycles after start was sampled.
    for (int es = 0; es < 600; es++) begin
      if (prev_stall) begin
        check("stall_addr", 64'(wr_addr), 64'(pa));
        check("stall_data", 64'(wr_data), 64'(pd));
      end
      if (wr_en) begin
        if (k >= exp_q.size()) begin
          check("extra_write", 64'(k), 64'(exp_q.size()));
        end else begin
          ea = v.base + 19'(k);
          check("addr", 64'(wr_addr), 64'(ea));
          check("data", 64'(wr_data), 64'(exp_q[k]));
          if (k < 64) begin
            cap_a[k] = wr_addr;
            cap_d[k] = wr_data;
          end
        end
      end
      if (done) begin
        seen = 1;
        done_at = es;
      end
      start = (es == v.poke);
      wr_ready = pick(v.rnd);
      prev_stall = wr_en && !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      if (wr_en && wr_ready) begin
        k++;
        last_acc = es;
      end
      if (seen) break;
      @(negedge clk);
    end
    cap_n = k;
    check("done_seen", 64'(seen), 64'(1));
    exp_done = (v.exp_done >= 0) ? v.exp_done : last_acc + 2;
    check("done_cycle", 64'(done_at), 64'(exp_done));
    check("words", 64'(k), 64'(v.exp_n));
    check("count", 64'(count), 64'(v.exp_n));
    check("busy_at_done", 64'(busy), 64'(0));
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_wr_en", 64'(wr_en), 64'(0));
    for (int s = 0; s < 11; s++) begin
      if (spots[s].run == id && spots[s].idx < cap_n) begin
        check("spot_addr", 64'(cap_a[spots[s].idx]), 64'(spots[s].addr));
        check("spot_data", 64'(cap_d[spots[s].idx]), 64'(spots[s].data));
      end
    end
  endtask

  initial begin
    logic [35:0] dn, dp, d0, d4, m0, m1, m3;
    dn = {6'd0, 10'h39C, 10'h39C, 10'h39C};
    dp = {6'd0, 10'h064, 10'h064, 10'h064};
    d0 = 36'd0;
    d4 = {6'd0, 10'h39C, 10'h000, 10'h000};
    m0 = {6'd0, 10'h12C, 10'h064, 10'h064};
    m1 = {6'd0, 10'h12C, 10'h39C, 10'h064};
    m3 = {6'd0, 10'h12C, 10'h39C, 10'h39C};

    vecs[0] = '{1'b0, 19'd0,       19'd1000, 1'b0, -1, 27, 28};
    vecs[1] = '{1'b1, 19'd0,       19'd1000, 1'b0, -1, 31, 32};
    vecs[2] = '{1'b1, 19'd0,       19'd1000, 1'b1, -1, 31, -1};
    vecs[3] = '{1'b1, 19'd0,       19'd5,    1'b0, -1, 5,  6};
    vecs[4] = '{1'b0, 19'd0,       19'd0,    1'b0, -1, 0,  1};
    vecs[5] = '{1'b0, 19'h7FFFE,   19'd1000, 1'b0, -1, 27, 28};
    vecs[6] = '{1'b0, 19'd100,     19'd1000, 1'b0, 27, 27, 28};
    vecs[7] = '{1'b1, 19'd0,       19'd1000, 1'b0, 10, 31, 32};
    vecs[8] = '{1'b1, 19'd0,       19'd27,   1'b1, -1, 27, -1};
    vecs[9] = '{1'b0, 19'd0,       19'd1000, 1'b1, 5,  27, -1};

    spots[0]  = '{0, 0,  19'd0,     dn};
    spots[1]  = '{0, 13, 19'd13,    d0};
    spots[2]  = '{0, 26, 19'd26,    dp};
    spots[3]  = '{1, 27, 19'd27,    m0};
    spots[4]  = '{1, 28, 19'd28,    m1};
    spots[5]  = '{1, 30, 19'd30,    m3};
    spots[6]  = '{5, 0,  19'h7FFFE, dn};
    spots[7]  = '{5, 1,  19'h7FFFF, pk(-100, -100, 0)};
    spots[8]  = '{5, 2,  19'd0,     pk(-100, -100, 100)};
    spots[9]  = '{5, 26, 19'd24,    dp};
    spots[10] = '{3, 4,  19'd4,     d4};

    reset = 1'b1; start = 1'b0; mode = 1'b0; wr_ready = 1'b1; base_addr = '0; max_count = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while the 10th word is on the bus.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 19'd0; max_count = 19'd1000; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_addr", 64'(wr_addr), 64'(9));
    reset = 1'b1;
    @(negedge clk);
    check("mr_wr_en", 64'(wr_en), 64'(0));
    check("mr_wr_addr", 64'(wr_addr), 64'(0));
    check("mr_wr_data", 64'(wr_data), 64'(0));
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_done", 64'(done), 64'(0));
    check("mr_count", 64'(count), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_done", 64'(done), 64'(0));
      check("post_rst_wr_en", 64'(wr_en), 64'(0));
    end
    run_vec(vecs[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
